// File: rtl/branch_predictor.sv
// Bimodal/gshare branch predictor with a direct-mapped BTB.
// Same-cycle lookup for fetch, trained one cycle later from decode resolution.
module bp_entry #(
  parameter int          TAG_W    = 12,
  parameter int          ADDR_W   = 16,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btb_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [ADDR_W-1:0] wr_tgt,
  input  logic              ctr_we,
  input  logic              ctr_inc,
  output logic              vld,
  output logic [TAG_W-1:0]  tag,
  output logic [ADDR_W-1:0] tgt,
  output logic [1:0]        ctr
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      tag <= '0;
      tgt <= '0;
    end else if (btb_we) begin
      vld <= 1'b1;
      tag <= wr_tag;
      tgt <= wr_tgt;
    end
  end

  // 2-bit saturating counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ctr <= CTR_INIT;
    else if (ctr_we) begin
      if (ctr_inc && ctr != 2'b11)       ctr <= ctr + 2'd1;
      else if (!ctr_inc && ctr != 2'b00) ctr <= ctr - 2'd1;
    end
  end
endmodule

module branch_predictor #(
  parameter int         ADDR_W   = 16,
  parameter int         INDEX_W  = 3,
  parameter int         GHR_W    = 3,
  parameter int         GSHARE   = 0,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  input  logic              stat_clr,
  output logic [15:0]       branch_cnt,
  output logic [15:0]       mispredict_cnt
);
  localparam int TAG_W = ADDR_W - 1 - INDEX_W;
  localparam int N     = 1 << INDEX_W;

  logic [N-1:0]             vld;
  logic [N-1:0][TAG_W-1:0]  tag;
  logic [N-1:0][ADDR_W-1:0] tgt;
  logic [N-1:0][1:0]        ctr;
  logic [GHR_W-1:0]         ghr;
  logic [INDEX_W-1:0]       lk_bi, lk_ci, upd_bi, upd_ci;
  logic                     unused_pc0;

  // History is left-aligned into the index so short histories hit the MSBs.
  function automatic logic [INDEX_W-1:0] cidx(input logic [ADDR_W-1:0] pc,
                                               input logic [GHR_W-1:0]  h);
    logic [INDEX_W-1:0] hp;
    hp = INDEX_W'(h) << (INDEX_W - GHR_W);
    return (GSHARE != 0) ? (pc[INDEX_W:1] ^ hp) : pc[INDEX_W:1];
  endfunction

  assign lk_bi      = lookup_pc[INDEX_W:1];
  assign lk_ci      = cidx(lookup_pc, ghr);
  assign upd_bi     = upd_pc[INDEX_W:1];
  assign upd_ci     = cidx(upd_pc, upd_ghr);
  assign unused_pc0 = upd_pc[0];

  for (genvar i = 0; i < N; i++) begin : g_ent
    bp_entry #(.TAG_W(TAG_W), .ADDR_W(ADDR_W), .CTR_INIT(CTR_INIT)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .btb_we  (upd_en & upd_taken & (upd_bi == INDEX_W'(i))),
      .wr_tag  (upd_pc[ADDR_W-1:INDEX_W+1]),
      .wr_tgt  (upd_target),
      .ctr_we  (upd_en & (upd_ci == INDEX_W'(i))),
      .ctr_inc (upd_taken),
      .vld     (vld[i]),
      .tag     (tag[i]),
      .tgt     (tgt[i]),
      .ctr     (ctr[i])
    );
  end

  assign pred_hit    = vld[lk_bi] && (tag[lk_bi] == lookup_pc[ADDR_W-1:INDEX_W+1]);
  assign pred_taken  = pred_hit & ctr[lk_ci][1];
  assign pred_target = pred_taken ? tgt[lk_bi] : lookup_pc + ADDR_W'(2);
  assign pred_ghr    = ghr;
  assign mispredict  = upd_en & ((upd_taken != upd_pred_taken) |
                                 (upd_taken & (upd_target != upd_pred_target)));

  // History is rebuilt from the branch's own fetch-time snapshot to undo wrong-path shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ghr <= '0;
    else if (upd_en) ghr <= GHR_W'({upd_ghr, upd_taken});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (stat_clr) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (upd_en) begin
      if (branch_cnt != 16'hFFFF)                  branch_cnt     <= branch_cnt + 16'd1;
      if (mispredict && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor and branch target buffer (BTB) for the pipelined core. It answers same-cycle lookups for the fetch PC with a hit flag, a taken prediction and a target. It is trained one cycle later from decode-stage branch resolution. It supports bimodal or gshare indexing of its 2-bit saturating counters and keeps saturating prediction statistics.

## Interface
- ADDR_W, 16, instruction address width; PC is halfword aligned, bit 0 ignored.
- INDEX_W, 3, log2 of entry count for both BTB and counter table (8 entries).
- GHR_W, 3, global history length, 1..INDEX_W.
- GSHARE, 0, 0 = bimodal counter index, 1 = gshare counter index.
- CTR_INIT, 2'b01, counter reset value (weakly not-taken).
- TAG_W is derived: ADDR_W-1-INDEX_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- lookup_pc  in  ADDR_W  fetch-stage PC.
- pred_hit  out  1  BTB valid entry with matching tag for lookup_pc.
- pred_taken  out  1  predicted taken, pred_hit & ctr[1].
- pred_target  out  ADDR_W  BTB target if pred_taken, else lookup_pc+2.
- pred_ghr  out  GHR_W  current GHR; the pipeline carries it to decode.
- upd_en  in  1  a branch resolved in decode this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual branch target.
- upd_ghr  in  GHR_W  pred_ghr value captured when this branch was fetched.
- upd_pred_taken  in  1  pipelined pred_taken of this branch.
- upd_pred_target  in  ADDR_W  pipelined pred_target of this branch.
- mispredict  out  1  combinational flag for a wrong prediction on this branch.
- stat_clr  in  1  synchronous clear of the statistics counters.
- branch_cnt  out  16  resolved branches, saturating.
- mispredict_cnt  out  16  mispredictions, saturating.

## Operation
- Indexing:
  - BTB index bi(pc) = pc[INDEX_W:1].
  - Tag = pc[ADDR_W-1:INDEX_W+1].
  - Counter index for bimodal: ci = bi(pc).
  - Counter index for gshare: ci = bi(pc) XOR {GHR, zero-padded at LSB side to INDEX_W}.
- Lookup is purely combinational from current state. It uses the live GHR.
- mispredict = upd_en & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
- On upd_en, at the next rising edge:
  - Counter at ci(upd_pc, upd_ghr) increments if taken, decrements if not-taken. It saturates at 2'b11 and 2'b00.
  - If upd_taken: BTB entry bi(upd_pc) is written with valid=1, tag, upd_target. This overwrites any aliasing entry.
  - If not taken: the BTB is unchanged. There is no allocation and no invalidation.
  - GHR becomes {upd_ghr[GHR_W-2:0], upd_taken}. This repairs history after a wrong path; for GHR_W=1 it becomes upd_taken.
  - branch_cnt increments, saturating at 16'hFFFF.
  - mispredict_cnt increments if mispredict, saturating at 16'hFFFF.
- stat_clr zeroes both statistics counters. It has priority over a same-cycle increment. It does not touch the tables or the GHR.
- upd_en low: no state changes except stat_clr.

## Timing
- Reset (asynchronous, immediate) sets every BTB valid to 0, every counter to CTR_INIT, GHR to 0 and both statistics counters to 0.
- Outputs during reset:
  - pred_hit=0, pred_taken=0, pred_target=lookup_pc+2, pred_ghr=0.
  - mispredict follows its equation.
  - branch_cnt=0, mispredict_cnt=0.
- Lookup latency is 0 cycles. Update latency is 1 cycle: a lookup in the cycle after the update edge sees the new state.
- A simultaneous lookup and update of the same entry returns the pre-update contents in that cycle.
- pred_target arithmetic is modulo 2^ADDR_W (wraps 16'hFFFE+2 to 16'h0000).
- Reset asserted mid-operation discards any pending update. Deassertion needs no recovery cycles.

## Test plan
- Reset, then lookup_pc=16'h0010: pred_hit=0, pred_taken=0, pred_target=16'h0012. All counters read CTR_INIT through behaviour; both stats are 0.
- Bimodal training:
  - Update pc=16'h0010 taken, target=16'h0040 once: the next-cycle lookup gives hit=1, ctr=2'b10, pred_taken=1, pred_target=16'h0040.
  - Two more taken updates, then three not-taken: the counter goes 11 (saturates), then 10, 01, 00, so pred_taken=0.
- Aliasing: train 16'h0010 taken, then update 16'h0020 taken to 16'h0080. Both share bi=0, so a lookup of 16'h0010 gives hit=0 and target 16'h0012.
- Gshare (GSHARE=1): same pc, update with upd_ghr=3'b000 versus 3'b101. Separate counters train independently. The GHR after a taken update with upd_ghr=3'b101 reads 3'b011.
- Mispredict and statistics: upd_pred_taken=1 with upd_taken=0 gives mispredict=1. Taken with upd_pred_target≠upd_target also gives 1. Counters saturate at 16'hFFFF after 65536+ updates. stat_clr coincident with upd_en yields 0.
- Reset asserted asynchronously between clock edges while entries are valid: outputs drop to reset values immediately, and the following lookups miss.
